fpu_scheduler: RTL and testbench
================================

# fpu_scheduler

Shares one multi-cycle FPU adder between `N_REQ` requesters. The FPU has no start/done handshake; it restarts when its reset is pulsed and its result is valid a fixed number of cycles later. This block sits between the requesters and the FPU. It does the following:
- arbitrates round-robin between requesters;
- latches the selected operands;
- pulses the FPU reset to start a fresh operation;
- counts the FPU latency;
- returns `data_out`/`status_out` to the winner over a valid/ready response channel.

## Interface
- `N_REQ`, 2: number of requesters (≥2).
- `LATENCY`, 6: clock cycles from FPU reset release to a stable FPU result (≥1).
- `clock` in 1: single clock for block and FPU.
- `reset` in 1: asynchronous, active-low.
- `req_valid` in N_REQ: per-requester operation request.
- `req_ready` out N_REQ: request accepted this cycle (one-hot or zero).
- `req_op_a` in 32*N_REQ: operand A of requester i at bits [32i+31:32i]. Format is 1 sign, 6 exponent (bias 31), 25 mantissa.
- `req_op_b` in 32*N_REQ: operand B, same packing.
- `rsp_valid` out 1: result held for the granted requester.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_id` out $clog2(N_REQ): index of the requester that owns the result.
- `rsp_data` out 32: captured FPU `data_out`.
- `rsp_status` out 4: captured FPU `status_out`, passed through unmodified.
- `fpu_reset` out 1: active-low restart to the FPU `reset` pin.
- `fpu_op_A` out 32: operand A to the FPU.
- `fpu_op_B` out 32: operand B to the FPU.
- `fpu_data_in` in 32: FPU `data_out`.
- `fpu_status_in` in 4: FPU `status_out`.

## Operation
The block is a four-state FSM: `IDLE`, `CLEAR`, `RUN`, `DONE`.

- **IDLE:** the arbiter picks the first asserting `req_valid`, scanning upward from `rr_ptr+1` with wrap. `req_ready[g]` is driven combinationally high for the winner only. On that edge the block:
  - latches the winner's operands into `op_a_q`/`op_b_q`;
  - latches `g` into `rsp_id`;
  - sets `rr_ptr` to `g`;
  - moves to `CLEAR`.
- **Other states:** `req_ready` is all zero.
- **CLEAR:** lasts one cycle with `fpu_reset`=0. It then moves to `RUN` and loads the counter with `LATENCY-1`.
- **RUN:** `fpu_reset`=1 and the counter decrements each cycle. On the edge where the counter is 0, the block captures `fpu_data_in`/`fpu_status_in` into `rsp_data`/`rsp_status` and moves to `DONE`.
- **DONE:** `rsp_valid`=1, and `rsp_*` stay stable until `rsp_valid && rsp_ready`. It then returns to `IDLE`.
- **FPU operands:** `fpu_op_A`/`fpu_op_B` are driven from `op_a_q`/`op_b_q` at all times. They never change in `CLEAR` or `RUN`.
- **Request withdrawal:** a requester that drops `req_valid` without seeing `req_ready` loses nothing. Requests are not queued.
- **Fairness:** with all requesters valid continuously, grants rotate 0,1,…,N_REQ-1,0. With only one valid requester, it is granted back-to-back.

## Timing
- **Reset values:**
  - FSM is in `IDLE`;
  - `rr_ptr` = N_REQ-1, so requester 0 wins first;
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_status`=0;
  - `op_a_q`=`op_b_q`=0;
  - counter = 0.
- **`fpu_reset` during reset:** `fpu_reset` = `reset` AND (state≠`CLEAR`). The FPU is therefore held in reset while the system is in reset, with no added delay.
- **Latency:** accept edge at cycle T. `CLEAR` is cycle T+1, `RUN` is T+2…T+1+LATENCY, and `rsp_valid` rises at T+2+LATENCY.
- **Earliest next acceptance:** the cycle after the response handshake. Minimum spacing between grants is LATENCY+3 cycles.
- **Same-cycle handshake:** `rsp_ready` may already be high when `rsp_valid` rises. The handshake then completes in that first `DONE` cycle.
- **Reset mid-operation:** all state returns to reset values immediately. Any in-flight result is discarded and no `rsp_valid` is produced.
- **Simultaneous requests:** `req_valid` changes in `CLEAR`/`RUN`/`DONE` have no effect. Arbitration samples only in `IDLE`.

## Structure
- **`fpu_pkg`** holds:
  - state enum `fpu_sched_state_t` {IDLE, CLEAR, RUN, DONE};
  - format constants `FP_W`=32, `EXP_W`=6, `MAN_W`=25, `EXP_BIAS`=31;
  - status width `FP_STATUS_W`=4.
- **`rr_arbiter`:** one sub-module. It is a purely combinational round-robin grant from `req_valid` and `rr_ptr`, with outputs one-hot grant plus an encoded index. The FSM, counter and capture registers stay in `fpu_scheduler`.

## Test plan
Benches run with the real `FPU` attached, `LATENCY` = 6.

1. Requester 0 only: A=0xBE000000, B=0xBE000000 (−1 + −1) accepted at T. Required: `fpu_reset` low exactly at T+1, `rsp_valid` at T+8, `rsp_id`=0, `rsp_data`=0xC0000000.
2. Both valid from reset:
   - requester 0 sends 0x40000000 + 0xC2000000;
   - requester 1 sends 0x3E000000 + 0xBE000000;
   - required: grant order 0,1,0. `rsp_data` is 0xC0000000 then 0x00000000, with the matching `rsp_id`.
3. Backpressure: `rsp_ready`=0 for 10 cycles in `DONE`. Required: `rsp_*` stable, `req_ready` stays 0 despite `req_valid`, and the next grant comes one cycle after `rsp_ready` rises.
4. Operand stability: change `req_op_a` every cycle after acceptance. Required: `fpu_op_A` is constant until the next grant.
5. Reset mid-`RUN` at accept+4. Required: immediate return to reset values, `fpu_reset`=0 while `reset`=0, no `rsp_valid`. After release, requester 0 wins first.
6. Same-cycle handshake: `rsp_ready` tied high. Required: `rsp_valid` lasts exactly one cycle, and back-to-back single-requester grants are spaced LATENCY+3 = 9 cycles apart.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and number-format constants for the FPU request scheduler.
package fpu_pkg;

  localparam int FP_W        = 32;
  localparam int EXP_W       = 6;
  localparam int MAN_W       = 25;
  localparam int EXP_BIAS    = 31;
  localparam int FP_STATUS_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } fpu_sched_state_t;

endpackage

// File: rtl/fpu_scheduler_if.sv
// Requester and response channels between the requesters/consumer and the FPU scheduler.
interface fpu_scheduler_if #(
  parameter int N_REQ = 2
) ();
  import fpu_pkg::*;

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Both channels transfer on a rising clock edge where valid && ready. req_ready is a
  // combinational grant (one-hot or zero); rsp_valid holds rsp_* stable until taken.
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [FP_W*N_REQ-1:0]  req_op_a;
  logic [FP_W*N_REQ-1:0]  req_op_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [FP_W-1:0]        rsp_data;
  logic [FP_STATUS_W-1:0] rsp_status;

  modport master (
    output req_valid, req_op_a, req_op_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_status
  );

  modport slave (
    input  req_valid, req_op_a, req_op_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_status
  );

endinterface

// File: rtl/fpu_scheduler_rr_arbiter.sv
// Combinational round-robin grant: scans upward from rr_ptr+1 with wrap.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_scheduler.sv
// Shares one reset-started, fixed-latency FPU adder between N_REQ requesters.
module fpu_scheduler
  import fpu_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int LATENCY = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  fpu_scheduler_if.slave         bus,
  output logic                   fpu_reset,
  output logic [FP_W-1:0]        fpu_op_A,
  output logic [FP_W-1:0]        fpu_op_B,
  input  logic [FP_W-1:0]        fpu_data_in,
  input  logic [FP_STATUS_W-1:0] fpu_status_in,
  output fpu_sched_state_t       dbg_state
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  fpu_sched_state_t       state, state_nx;
  logic [ID_W-1:0]        rr_ptr;
  logic [CNT_W-1:0]       cnt;
  logic [FP_W-1:0]        op_a_q, op_b_q;
  logic [ID_W-1:0]        rsp_id_q;
  logic [FP_W-1:0]        rsp_data_q;
  logic [FP_STATUS_W-1:0] rsp_status_q;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  logic [FP_W-1:0]  sel_a, sel_b;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a = bus.req_op_a[i*FP_W +: FP_W];
        sel_b = bus.req_op_b[i*FP_W +: FP_W];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_any) state_nx = CLEAR;
      CLEAR:   state_nx = RUN;
      RUN:     if (cnt == '0) state_nx = DONE;
      DONE:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= ID_W'(N_REQ - 1);
      cnt          <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          op_a_q   <= sel_a;
          op_b_q   <= sel_b;
          rsp_id_q <= grant_idx;
          rr_ptr   <= grant_idx;
        end
        CLEAR: cnt <= CNT_W'(LATENCY - 1);
        RUN: if (cnt == '0) begin
          rsp_data_q   <= fpu_data_in;
          rsp_status_q <= fpu_status_in;
        end else begin
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Gated by reset so the FPU is held in reset with the system, combinationally.
  assign fpu_reset      = reset & (state != CLEAR);
  assign bus.req_ready  = (reset && state == IDLE) ? grant : '0;
  assign bus.rsp_valid  = (state == DONE);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_status = rsp_status_q;
  assign fpu_op_A       = op_a_q;
  assign fpu_op_B       = op_b_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_fpu_scheduler.sv
// Directed bench for fpu_scheduler with a small reset-started fixed-latency FPU model.
module tb_fpu_scheduler;
  import fpu_pkg::*;

  localparam int N_REQ   = 2;
  localparam int LATENCY = 6;
  localparam int ID_W    = 1;

  typedef struct {
    logic [N_REQ-1:0] mask;
    logic [31:0]      a0, b0, a1, b1;
    logic [ID_W-1:0]  exp_id;
    logic [31:0]      exp_data;
    logic [3:0]       exp_status;
  } vec_t;

  logic clock, reset;
  logic fpu_reset;
  logic [31:0] fpu_op_A, fpu_op_B, fpu_data_in;
  logic [3:0]  fpu_status_in;
  fpu_sched_state_t dbg_state;

  fpu_scheduler_if #(.N_REQ(N_REQ)) bus ();

  fpu_scheduler #(.N_REQ(N_REQ), .LATENCY(LATENCY)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .fpu_reset     (fpu_reset),
    .fpu_op_A      (fpu_op_A),
    .fpu_op_B      (fpu_op_B),
    .fpu_data_in   (fpu_data_in),
    .fpu_status_in (fpu_status_in),
    .dbg_state     (dbg_state)
  );

  vec_t        vecs [8];
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int run_cyc  = 0;
  logic [31:0] fpu_r;

  // Clock and cycle counter
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // FPU model: hand-computed sums, junk until LATENCY cycles after reset release
  function automatic logic [31:0] fpu_sum(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'hBE000000 && b == 32'hBE000000) return 32'hC0000000;
    if (a == 32'h40000000 && b == 32'hC2000000) return 32'hC0000000;
    if (a == 32'h3E000000 && b == 32'hBE000000) return 32'h00000000;
    if (a == 32'h40000000 && b == 32'h40000000) return 32'h42000000;
    if (a == 32'h3E000000 && b == 32'h3E000000) return 32'h40000000;
    return a ^ b ^ 32'h5A5A5A5A;
  endfunction

  always @(posedge clock) begin
    if (!fpu_reset)          run_cyc <= 0;
    else if (run_cyc < 1000) run_cyc <= run_cyc + 1;
  end

  always_comb begin
    fpu_r         = fpu_sum(fpu_op_A, fpu_op_B);
    fpu_data_in   = 32'hDEADBEEF;
    fpu_status_in = 4'hF;
    if (fpu_reset && run_cyc >= LATENCY - 1) begin
      fpu_data_in   = fpu_r;
      fpu_status_in = {2'b00, fpu_r[31], (fpu_r == 32'h0)};
    end
  end

  // Driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic [N_REQ-1:0] mask, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] a1, input logic [31:0] b1);
    bus.req_valid = mask;
    bus.req_op_a  = {a1, a0};
    bus.req_op_b  = {b1, b0};
  endtask

  task automatic wait_grant(output logic [N_REQ-1:0] g);
    int n;
    n = 0;
    #1;
    while (bus.req_ready == '0 && n < 30) begin
      @(negedge clock);
      #1;
      n++;
    end
    g = bus.req_ready;
  endtask

  // Entered on the negedge right after the accept edge (CLEAR cycle).
  task automatic wait_rsp(input logic [ID_W-1:0] exp_id, input logic [3:0] exp_status);
    int n;
    logic [31:0] exp_data;
    check("clear_fpu_reset_low", fpu_reset, 1'b0);
    n = 0;
    while (!bus.rsp_valid && n < 30) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (n == 1) check("run_fpu_reset_high", fpu_reset, 1'b1);
    end
    check("rsp_latency", n, LATENCY + 1);
    exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
    check("rsp_id", bus.rsp_id, exp_id);
    check("rsp_data", bus.rsp_data, exp_data);
    check("rsp_status", bus.rsp_status, exp_status);
  endtask

  task automatic rsp_take();
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    check("rsp_valid_after_take", bus.rsp_valid, 1'b0);
  endtask

  initial begin
    logic [N_REQ-1:0] g;
    logic [N_REQ-1:0] one_hot;
    logic [31:0] d;
    int g_cyc [$];
    int run;
    int rsp_cycles;

    reset = 1'b0;
    bus.rsp_ready = 1'b0;
    drive_req('0, 32'h0, 32'h0, 32'h0, 32'h0);

    vecs[0] = '{2'b11, 32'h40000000, 32'hC2000000, 32'h3E000000, 32'hBE000000, 1'b0, 32'hC0000000, 4'h2};
    vecs[1] = '{2'b11, 32'h40000000, 32'hC2000000, 32'h3E000000, 32'hBE000000, 1'b1, 32'h00000000, 4'h1};
    vecs[2] = '{2'b11, 32'h40000000, 32'hC2000000, 32'h3E000000, 32'hBE000000, 1'b0, 32'hC0000000, 4'h2};
    vecs[3] = '{2'b01, 32'hBE000000, 32'hBE000000, 32'h00000000, 32'h00000000, 1'b0, 32'hC0000000, 4'h2};
    vecs[4] = '{2'b10, 32'h00000000, 32'h00000000, 32'h40000000, 32'h40000000, 1'b1, 32'h42000000, 4'h0};
    vecs[5] = '{2'b10, 32'h00000000, 32'h00000000, 32'h3E000000, 32'h3E000000, 1'b1, 32'h40000000, 4'h0};
    vecs[6] = '{2'b11, 32'h3E000000, 32'hBE000000, 32'hBE000000, 32'hBE000000, 1'b0, 32'h00000000, 4'h1};
    vecs[7] = '{2'b11, 32'h40000000, 32'h40000000, 32'h40000000, 32'hC2000000, 1'b1, 32'hC0000000, 4'h2};

    // Reset values, with requests asserted during reset
    repeat (2) @(negedge clock);
    drive_req(2'b11, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    #1;
    check("rst_state", dbg_state, IDLE);
    check("rst_req_ready", bus.req_ready, 2'b00);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_id", bus.rsp_id, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 32'h0);
    check("rst_rsp_status", bus.rsp_status, 4'h0);
    check("rst_fpu_op_A", fpu_op_A, 32'h0);
    check("rst_fpu_op_B", fpu_op_B, 32'h0);
    check("rst_fpu_reset", fpu_reset, 1'b0);
    @(negedge clock);
    drive_req('0, 32'h0, 32'h0, 32'h0, 32'h0);
    reset = 1'b1;
    #1;
    check("rel_fpu_reset", fpu_reset, 1'b1);
    @(negedge clock);

    // Table-driven vectors: rotation, single-requester back-to-back, sums
    for (int i = 0; i < 8; i++) begin
      drive_req(vecs[i].mask, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1);
      wait_grant(g);
      one_hot = '0;
      one_hot[vecs[i].exp_id] = 1'b1;
      check("grant", g, one_hot);
      exp_q.push_back(vecs[i].exp_data);
      @(posedge clock);
      @(negedge clock);
      bus.req_valid = '0;
      wait_rsp(vecs[i].exp_id, vecs[i].exp_status);
      rsp_take();
    end

    // Backpressure and operand stability while requests stay asserted
    drive_req(2'b11, 32'h40000000, 32'h40000000, 32'h3E000000, 32'hBE000000);
    wait_grant(g);
    check("bp_grant", g, 2'b01);
    exp_q.push_back(32'h42000000);
    @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < LATENCY + 1; k++) begin
      bus.req_op_a = {$urandom(), $urandom()};
      #1;
      check("op_a_stable_busy", fpu_op_A, 32'h40000000);
      check("req_ready_busy", bus.req_ready, 2'b00);
      @(negedge clock);
    end
    check("bp_rsp_valid_rise", bus.rsp_valid, 1'b1);
    d = exp_q.pop_front();
    for (int k = 0; k < 10; k++) begin
      bus.req_op_a = {$urandom(), $urandom()};
      #1;
      check("bp_rsp_valid", bus.rsp_valid, 1'b1);
      check("bp_rsp_data", bus.rsp_data, d);
      check("bp_rsp_status", bus.rsp_status, 4'h0);
      check("bp_rsp_id", bus.rsp_id, 1'b0);
      check("bp_req_ready", bus.req_ready, 2'b00);
      check("op_a_stable_done", fpu_op_A, 32'h40000000);
      @(negedge clock);
    end
    drive_req(2'b11, 32'h3E000000, 32'hBE000000, 32'hBE000000, 32'hBE000000);
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    #1;
    check("bp_next_grant", bus.req_ready, 2'b10);
    check("op_a_until_grant", fpu_op_A, 32'h40000000);
    exp_q.push_back(32'hC0000000);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = '0;
    wait_rsp(1'b1, 4'h2);
    rsp_take();

    // Reset in the middle of RUN discards the operation
    drive_req(2'b11, 32'hBE000000, 32'hBE000000, 32'h40000000, 32'hC2000000);
    wait_grant(g);
    check("mr_grant", g, 2'b01);
    @(posedge clock);
    @(negedge clock);
    repeat (3) @(negedge clock);
    check("mr_in_run", dbg_state, RUN);
    reset = 1'b0;
    #1;
    check("mr_state", dbg_state, IDLE);
    check("mr_rsp_valid", bus.rsp_valid, 1'b0);
    check("mr_req_ready", bus.req_ready, 2'b00);
    check("mr_fpu_reset", fpu_reset, 1'b0);
    check("mr_fpu_op_A", fpu_op_A, 32'h0);
    check("mr_rsp_data", bus.rsp_data, 32'h0);
    check("mr_rsp_id", bus.rsp_id, 1'b0);
    check("mr_rsp_status", bus.rsp_status, 4'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("mr_hold_rsp_valid", bus.rsp_valid, 1'b0);
      check("mr_hold_fpu_reset", fpu_reset, 1'b0);
    end
    reset = 1'b1;
    #1;
    check("mr_first_grant", bus.req_ready, 2'b01);
    exp_q.push_back(32'hC0000000);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = '0;
    wait_rsp(1'b0, 4'h2);
    rsp_take();

    // rsp_ready tied high: one-cycle rsp_valid, grants LATENCY+3 apart
    bus.rsp_ready = 1'b1;
    drive_req(2'b01, 32'hBE000000, 32'hBE000000, 32'h0, 32'h0);
    run = 0;
    rsp_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus.req_ready[0]) g_cyc.push_back(cyc);
      if (bus.rsp_valid) begin
        run++;
        rsp_cycles++;
        check("sc_rsp_data", bus.rsp_data, 32'hC0000000);
      end else begin
        if (run != 0) check("sc_rsp_valid_width", run, 1);
        run = 0;
      end
      @(negedge clock);
    end
    check("sc_rsp_count", rsp_cycles, 4);
    check("sc_grant_count", g_cyc.size(), 5);
    for (int i = 1; i < g_cyc.size(); i++)
      check("sc_grant_spacing", g_cyc[i] - g_cyc[i-1], LATENCY + 3);
    bus.req_valid = '0;
    repeat (12) @(negedge clock);
    check("sc_drained", dbg_state, IDLE);
    bus.rsp_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
